// File: rtl/rr_sub_sched.sv
// Round-robin scheduler sharing one single-port processing sub-module among REQ_NUM requesters.
// Optional wait watchdog: define SCHED_TIMEOUT_EN to enable the err_o timeout path.
module rr_sub_sched #(
    parameter int REQ_NUM     = 4,
    parameter int DATA_WD     = 10,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REQ_NUM-1:0]         req_i,
    input  logic [REQ_NUM*DATA_WD-1:0] req_dat_i,
    output logic [REQ_NUM-1:0]         gnt_o,
    output logic                       sub_start_o,
    output logic [DATA_WD-1:0]         sub_dat_o,
    input  logic                       sub_done_i,
    input  logic [DATA_WD-1:0]         sub_res_i,
    output logic [REQ_NUM-1:0]         rsp_vld_o,
    output logic [DATA_WD-1:0]         rsp_dat_o,
    output logic                       busy_o,
    output logic                       err_o,
    output logic [1:0]                 dbg_state_o
);
    // Handshake: a requester holds req_i high until its own one-cycle rsp_vld_o;
    // the sub-module sees one sub_start_o pulse and answers with one sub_done_i pulse.
    localparam int PTR_W = $clog2(REQ_NUM);

    if (REQ_NUM < 2 || REQ_NUM > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("rr_sub_sched: REQ_NUM must be 2..8 and TIMEOUT_CYC at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_win;
    logic [REQ_NUM-1:0]   r_gnt;
    logic [REQ_NUM-1:0]   r_rsp_vld;
    logic                 r_sub_start;
    logic                 r_busy;
    logic [DATA_WD-1:0]   r_sub_dat;
    logic [DATA_WD-1:0]   r_rsp_dat;

    logic                 w_win_vld;
    logic [PTR_W-1:0]     w_win_idx;
    logic [PTR_W-1:0]     w_cand_idx;
    logic [REQ_NUM-1:0]   w_win_oh;
    logic [DATA_WD-1:0]   w_win_dat;
    logic [PTR_W-1:0]     w_ptr_nxt;
    int                   w_cand;

    // Scan from the lowest rotated offset last so the requester nearest the pointer wins.
    always_comb begin
        w_win_vld  = |req_i;
        w_win_idx  = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            w_cand = int'(r_ptr) + i;
            if (w_cand >= REQ_NUM) begin
                w_cand = w_cand - REQ_NUM;
            end
            w_cand_idx = PTR_W'(w_cand);
            if (req_i[w_cand_idx]) begin
                w_win_idx = w_cand_idx;
            end
        end
    end

    always_comb begin
        w_win_oh  = '0;
        w_win_dat = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (w_win_idx == PTR_W'(k)) begin
                w_win_oh[k] = 1'b1;
                w_win_dat   = req_dat_i[k*DATA_WD +: DATA_WD];
            end
        end
    end

    assign w_ptr_nxt = (r_win == PTR_W'(REQ_NUM - 1)) ? '0 : r_win + 1'b1;

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_tmo;

    // The limit is reached on the TIMEOUT_CYC-th wait cycle; a done in that cycle still wins.
    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_gnt       <= '0;
            r_rsp_vld   <= '0;
            r_sub_start <= 1'b0;
            r_busy      <= 1'b0;
            r_sub_dat   <= '0;
            r_rsp_dat   <= '0;
`ifdef SCHED_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        r_win       <= w_win_idx;
                        r_gnt       <= w_win_oh;
                        r_sub_dat   <= w_win_dat;
                        r_sub_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    r_sub_start <= 1'b0;
                    r_state     <= ST_WAIT;
`ifdef SCHED_TIMEOUT_EN
                    r_cnt       <= '0;
`endif
                end
                ST_WAIT: begin
                    if (sub_done_i) begin
                        r_rsp_dat <= sub_res_i;
                        r_rsp_vld <= r_gnt;
                        r_state   <= ST_RESP;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_rsp_dat <= '1;
                        r_rsp_vld <= r_gnt;
                        r_err     <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    r_gnt     <= '0;
                    r_rsp_vld <= '0;
                    r_busy    <= 1'b0;
                    r_ptr     <= w_ptr_nxt;
                    r_state   <= ST_IDLE;
`ifdef SCHED_TIMEOUT_EN
                    r_err     <= 1'b0;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign sub_start_o = r_sub_start;
    assign sub_dat_o   = r_sub_dat;
    assign rsp_vld_o   = r_rsp_vld;
    assign rsp_dat_o   = r_rsp_dat;
    assign busy_o      = r_busy;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rr_sub_sched.sv
// Directed bench for rr_sub_sched: grant order, latency, withdrawal, reset mid-service, optional timeout.
module tb_rr_sub_sched;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [39:0] req_dat_i;
    logic [3:0]  gnt_o;
    logic        sub_start_o;
    logic [9:0]  sub_dat_o;
    logic        sub_done_i;
    logic [9:0]  sub_res_i;
    logic [3:0]  rsp_vld_o;
    logic [9:0]  rsp_dat_o;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] ops [4];
    logic [9:0] rr_res [5];
    int         rr_idx [5];

    rr_sub_sched #(.REQ_NUM(4), .DATA_WD(10), .TIMEOUT_CYC(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .req_dat_i   (req_dat_i),
        .gnt_o       (gnt_o),
        .sub_start_o (sub_start_o),
        .sub_dat_o   (sub_dat_o),
        .sub_done_i  (sub_done_i),
        .sub_res_i   (sub_res_i),
        .rsp_vld_o   (rsp_vld_o),
        .rsp_dat_o   (rsp_dat_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .dbg_state_o (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller has raised req_i in an idle cycle; done arrives dly cycles after the start pulse.
    task automatic service(input string tag, input logic [3:0] exp_gnt, input logic [9:0] exp_op,
                           input int dly, input logic [9:0] res, input bit drop);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (gnt_o == 4'b0 && cyc < 20);
        check_val({tag, "_gnt"}, gnt_o, exp_gnt);
        check_val({tag, "_lat"}, cyc, 1);
        check_val({tag, "_start"}, sub_start_o, 1);
        check_val({tag, "_op"}, sub_dat_o, exp_op);
        check_val({tag, "_busy"}, busy_o, 1);
        tick();
        check_val({tag, "_start_clr"}, sub_start_o, 0);
        check_val({tag, "_st_wait"}, dbg_state_o, 2);
        if (drop) req_i = 4'b0;
        repeat (dly - 1) tick();
        sub_done_i = 1'b1;
        sub_res_i  = res;
        tick();
        sub_done_i = 1'b0;
        sub_res_i  = 10'h000;
        check_val({tag, "_rsp_vld"}, rsp_vld_o, exp_gnt);
        check_val({tag, "_rsp_dat"}, rsp_dat_o, res);
        check_val({tag, "_gnt_hold"}, gnt_o, exp_gnt);
        check_val({tag, "_op_hold"}, sub_dat_o, exp_op);
        check_val({tag, "_err"}, err_o, 0);
        tick();
        check_val({tag, "_rsp_clr"}, rsp_vld_o, 0);
        check_val({tag, "_gnt_clr"}, gnt_o, 0);
        check_val({tag, "_idle"}, busy_o, 0);
        check_val({tag, "_dat_keep"}, rsp_dat_o, res);
    endtask

    initial begin
        ops[0] = 10'h011; ops[1] = 10'h122; ops[2] = 10'h155; ops[3] = 10'h2CC;
        rr_idx[0] = 0; rr_idx[1] = 1; rr_idx[2] = 2; rr_idx[3] = 3; rr_idx[4] = 0;
        rr_res[0] = 10'h301; rr_res[1] = 10'h0F2; rr_res[2] = 10'h1E3;
        rr_res[3] = 10'h014; rr_res[4] = 10'h3C5;
        rst_n      = 1'b0;
        req_i      = 4'b0;
        req_dat_i  = {ops[3], ops[2], ops[1], ops[0]};
        sub_done_i = 1'b0;
        sub_res_i  = 10'h000;
        repeat (3) tick();
        check_val("rst_gnt", gnt_o, 0);
        check_val("rst_start", sub_start_o, 0);
        check_val("rst_op", sub_dat_o, 0);
        check_val("rst_rsp", rsp_vld_o, 0);
        check_val("rst_dat", rsp_dat_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_err", err_o, 0);
        check_val("rst_state", dbg_state_o, 0);
        rst_n = 1'b1;
        tick();

        req_i = 4'b0100;
        service("single", 4'b0100, 10'h155, 3, 10'h0AA, 1'b0);
        req_i = 4'b1000;
        service("req3", 4'b1000, ops[3], 2, 10'h201, 1'b0);

        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            service($sformatf("rr%0d", k), 4'(1 << rr_idx[k]), ops[rr_idx[k]], 2, rr_res[k], 1'b0);
        end

        req_i = 4'b1001;
        service("wrap_a", 4'b1000, ops[3], 2, 10'h155, 1'b0);
        service("wrap_b", 4'b0001, ops[0], 4, 10'h2AA, 1'b0);

        req_i = 4'b0010;
        service("withdraw", 4'b0010, ops[1], 3, 10'h0C3, 1'b1);

        req_i = 4'b0001;
        tick();
        check_val("mrst_gnt_pre", gnt_o, 4'b0001);
        tick();
        tick();
        check_val("mrst_st_wait", dbg_state_o, 2);
        rst_n = 1'b0;
        req_i = 4'b0;
        #1;
        check_val("mrst_gnt", gnt_o, 0);
        check_val("mrst_op", sub_dat_o, 0);
        check_val("mrst_dat", rsp_dat_o, 0);
        check_val("mrst_busy", busy_o, 0);
        check_val("mrst_state", dbg_state_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        sub_done_i = 1'b1;
        sub_res_i  = 10'h3FF;
        tick();
        sub_done_i = 1'b0;
        sub_res_i  = 10'h000;
        check_val("mrst_no_rsp", rsp_vld_o, 0);
        check_val("mrst_no_dat", rsp_dat_o, 0);
        check_val("mrst_idle", busy_o, 0);
        tick();
        check_val("mrst_no_rsp2", rsp_vld_o, 0);
        check_val("mrst_no_gnt", gnt_o, 0);

        req_i = 4'b1111;
        service("ptr_rst", 4'b0001, ops[0], 2, 10'h0F0, 1'b0);
        req_i = 4'b0;
        tick();

`ifdef SCHED_TIMEOUT_EN
        begin
            int cyc;
            req_i = 4'b0001;
            tick();
            check_val("tmo_gnt", gnt_o, 4'b0001);
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (rsp_vld_o == 4'b0 && cyc < 40);
            check_val("tmo_lat", cyc, 16);
            check_val("tmo_rsp", rsp_vld_o, 4'b0001);
            check_val("tmo_dat", rsp_dat_o, 10'h3FF);
            check_val("tmo_err", err_o, 1);
            tick();
            check_val("tmo_err_clr", err_o, 0);
            check_val("tmo_rsp_clr", rsp_vld_o, 0);
            service("tmo_edge", 4'b0001, ops[0], 15, 10'h123, 1'b0);
            req_i = 4'b0;
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_sub_sched.md
Name: rr_sub_sched

Overview:
- Round-robin scheduler that shares one instance of the team's single-port processing sub-module among REQ_NUM requesters.
- Arbitrates requests, hands the winner's operand to the sub-module and issues a start pulse.
- Waits for the sub-module's done, then returns the result to the winning requester only.
- Sits between the requester logic and the shared sub-module instance in the datapath.

Parameters:
REQ_NUM, 4, number of requesters (2..8)
DATA_WD, 10, operand/result width
TIMEOUT_CYC, 15, watchdog limit in cycles (used only with SCHED_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_i  input  REQ_NUM  per-requester request, level; held until own rsp_vld_o
req_dat_i  input  REQ_NUM*DATA_WD  operands, requester k at bits [k*DATA_WD +: DATA_WD]
gnt_o  output  REQ_NUM  one-hot grant, high from arbitration until end of response
sub_start_o  output  1  one-cycle start pulse to sub-module
sub_dat_o  output  DATA_WD  operand to sub-module, stable while granted
sub_done_i  input  1  sub-module completion pulse
sub_res_i  input  DATA_WD  sub-module result, valid with sub_done_i
rsp_vld_o  output  REQ_NUM  one-hot, one-cycle response valid
rsp_dat_o  output  DATA_WD  result, valid with rsp_vld_o
busy_o  output  1  high in any state other than ST_IDLE
err_o  output  1  one-cycle timeout pulse (constant 0 without macro)

Behaviour:
- Decided: reset rst_n, asynchronous, active-low; clock clk.
- All outputs are registered. Reset values:
  - gnt_o, rsp_vld_o, sub_start_o, err_o, busy_o = 0.
  - sub_dat_o, rsp_dat_o = 0.
  - Priority pointer = 0 (requester 0 highest); state = ST_IDLE.
- FSM, 2-bit state:
  - ST_IDLE: if any req_i, select the winner by rotating priority starting at the pointer. Next cycle: gnt_o one-hot, sub_dat_o = winner operand, sub_start_o = 1, state ST_START. Otherwise stay.
  - ST_START: lasts one cycle. sub_start_o returns to 0 on exit; next state ST_WAIT. sub_done_i in this state is ignored.
  - ST_WAIT: on sub_done_i, capture sub_res_i into rsp_dat_o, assert rsp_vld_o[winner] next cycle, state ST_RESP.
  - ST_RESP: lasts one cycle. On exit:
    - clear gnt_o and rsp_vld_o;
    - pointer = (winner+1) mod REQ_NUM;
    - return to ST_IDLE.
- Latency:
  - req_i high in ST_IDLE at cycle n gives sub_start_o/gnt_o at n+1.
  - sub_done_i at cycle m gives rsp_vld_o at m+1.
  - Minimum turnaround from back-to-back requests: 1 idle cycle between a response and the next grant.
- rsp_dat_o holds its last value until the next capture.
- req_i deassertion while granted is ignored; the service completes and the response is still issued.
- Requests arriving during service wait; a single requester is never starved beyond REQ_NUM-1 other services.
- Pointer wrap: winner REQ_NUM-1 gives pointer 0.
- Async reset mid-operation returns to ST_IDLE immediately with all outputs at reset values. A sub-module done arriving later is ignored, because it is only honoured in ST_WAIT.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- Defined:
  - A counter, width clog2(TIMEOUT_CYC+1), clears on entering ST_WAIT and increments each ST_WAIT cycle.
  - When it reaches TIMEOUT_CYC without sub_done_i: err_o pulses 1 cycle; rsp_vld_o[winner] pulses with rsp_dat_o = all ones; the pointer advances; the FSM returns to ST_IDLE via ST_RESP.
  - sub_done_i in the same cycle as the limit wins over the timeout; no err_o is issued.
- Undefined: no counter; err_o tied 0; ST_WAIT waits indefinitely.

Test Plan:
- Single request: req_i=4'b0100 with operand 10'h155, sub_done_i 3 cycles after start with sub_res_i=10'h0AA.
  -> gnt_o=4'b0100 and sub_start_o 1 cycle after req, sub_dat_o=10'h155.
  -> rsp_vld_o=4'b0100 and rsp_dat_o=10'h0AA 1 cycle after done.
- All four requests held, done 2 cycles after each start -> grants in order 0,1,2,3,0; each rsp_vld_o matches the preceding grant.
- Pointer wrap: after serving requester 3, req_i=4'b1001 -> requester 0 granted.
- Withdrawal: req_i[1] dropped during ST_WAIT -> rsp_vld_o[1] still pulses after sub_done_i.
- Reset mid-operation: rst_n low during ST_WAIT, then sub_done_i after release with req_i=0 -> all outputs 0, no rsp_vld_o, busy_o=0.
- SCHED_TIMEOUT_EN with TIMEOUT_CYC=15 and no sub_done_i -> err_o and rsp_vld_o pulse after 15 ST_WAIT cycles with rsp_dat_o=10'h3FF. Done arriving exactly on cycle 15 -> normal response, err_o stays 0.
